// File: rtl/spram_line_arbiter_if.sv
// Writer request channel and SPRAM port bundled for the line arbiter.
// The slave side is the arbiter; the master side is the writer plus the RAM itself.
interface spram_line_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
) ();
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          sp_cs;
  logic          sp_we;
  logic [AW-1:0] sp_addr;
  logic [DW-1:0] sp_wdata;
  logic [DW-1:0] sp_rdata;

  modport slave (
    input  wr_req, wr_addr, wr_data, sp_rdata,
    output wr_ack, sp_cs, sp_we, sp_addr, sp_wdata
  );

  modport master (
    output wr_req, wr_addr, wr_data, sp_rdata,
    input  wr_ack, sp_cs, sp_we, sp_addr, sp_wdata
  );
endinterface

// File: rtl/spram_line_arbiter.sv
// Single-port frame store arbiter: whole-row fetches for the display take strict
// priority over single-word writes from the image writer.
//
// state | meaning
// IDLE  | no SPRAM access; waiting for a line fetch or a write request
// WRITE | one-cycle SPRAM write of wr_addr/wr_data, acknowledged the same cycle
// READ  | streaming one row, one SPRAM read per cycle, columns 0..W-1
module spram_line_arbiter #(
  parameter int W  = 200,
  parameter int H  = 150,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 rd_line_sig,
  spram_line_arbiter_if.slave  bus,
  output logic                 pix_valid,
  output logic [DW-1:0]        pix_data,
  output logic [11:0]          pix_col,
  output logic                 busy,
  output logic                 err_overrun
);

  localparam int RW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row_cnt;
  logic [11:0]   col_cnt;
  logic [AW-1:0] base;
  logic [AW-1:0] row_base;
  logic          rd_pending;
  logic          fs_seen;
  logic          rd_req;
  logic          line_done;
  logic          enter_read;

  assign rd_req     = rd_pending | rd_line_sig;
  assign line_done  = (state == READ) && (col_cnt == 12'(W - 1));
  assign enter_read = (state != READ) && (state_nxt == READ);
  assign row_base   = AW'(row_cnt) * AW'(W);
  assign busy       = (state != IDLE);

  // sp_rdata arrives the cycle after the read issue, which is exactly when
  // pix_valid is up, so the data is passed through rather than re-registered.
  assign pix_data = pix_valid ? bus.sp_rdata : '0;

  always_comb begin
    state_nxt    = state;
    bus.wr_ack   = 1'b0;
    bus.sp_cs    = 1'b0;
    bus.sp_we    = 1'b0;
    bus.sp_addr  = '0;
    bus.sp_wdata = '0;
    case (state)
      IDLE: begin
        if (rd_req)
          state_nxt = READ;
        else if (bus.wr_req)
          state_nxt = WRITE;
      end
      WRITE: begin
        bus.sp_cs    = 1'b1;
        bus.sp_we    = 1'b1;
        bus.sp_addr  = bus.wr_addr;
        bus.sp_wdata = bus.wr_data;
        bus.wr_ack   = 1'b1;
        state_nxt    = rd_req ? READ : IDLE;
      end
      READ: begin
        bus.sp_cs   = 1'b1;
        bus.sp_addr = base + AW'(col_cnt);
        if (line_done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      row_cnt     <= '0;
      col_cnt     <= '0;
      base        <= '0;
      rd_pending  <= 1'b0;
      fs_seen     <= 1'b0;
      err_overrun <= 1'b0;
      pix_valid   <= 1'b0;
      pix_col     <= '0;
    end else begin
      state <= state_nxt;

      if (enter_read) begin
        base       <= frame_start ? '0 : row_base;
        col_cnt    <= '0;
        rd_pending <= 1'b0;
        fs_seen    <= 1'b0;
      end else begin
        if (state == WRITE && rd_line_sig)
          rd_pending <= 1'b1;
        if (state == READ)
          col_cnt <= line_done ? '0 : col_cnt + 12'd1;
        // a frame start mid-line keeps the row at 0 once the line finishes
        if (state == READ && frame_start)
          fs_seen <= 1'b1;
      end

      if (state == READ && rd_line_sig)
        err_overrun <= 1'b1;

      if (frame_start)
        row_cnt <= '0;
      else if (line_done)
        row_cnt <= (fs_seen || row_cnt == RW'(H - 1)) ? '0 : row_cnt + 1'b1;

      pix_valid <= (state == READ);
      pix_col   <= (state == READ) ? col_cnt : '0;
    end
  end

endmodule
